md5_padder: RTL

Front end for md5_core. It accepts a byte stream, forms 512-bit message blocks and applies MD5 padding: 0x80 marker, zero fill and a 64-bit little-endian bit length. It issues each block to the core with start (first block) or resume (continuation blocks), and signals when the core has finished the final block of a message. Internally it double-buffers, so the next block fills while the core is still hashing the current one.

---
 rtl/md5_pkg.sv | 26 ++
 rtl/md5_pad_tail.sv | 45 ++++
 rtl/md5_padder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md5_pkg
//  Description : Shared constants and types for the MD5 padding front end.
//                Holds the block geometry, the padding marker byte, the
//                block type (byte i at bits [8i:8i+7]) and the padder FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package md5_pkg;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef logic [0:511] blk_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PAD   = 2'd1,
        ST_EXTRA = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/md5_pad_tail.sv
`default_nettype none
// ============================================================================
//  Module      : md5_pad_tail
//  Description : Combinational builder for the last data-bearing block of a
//                message. Bytes below r are kept from the fill buffer, byte r
//                becomes the 0x80 marker and everything above it is zero.
//                When the marker leaves room (r <= 55) the 64-bit LE bit
//                length goes into bytes 56..63; otherwise extra_o requests
//                a separate length-only block.
//  Ports       : buf_i   - fill buffer contents
//                r_i     - number of valid message bytes in buf_i (0..63)
//                len_i   - message bit length, little-endian in the block
//                blk_o   - padded block
//                extra_o - a length-only block must follow
//  Revision    : 1.0 - initial release
// ============================================================================
module md5_pad_tail
    import md5_pkg::*;
(
    input  blk_t        buf_i,
    input  logic [5:0]  r_i,
    input  logic [63:0] len_i,
    output blk_t        blk_o,
    output logic        extra_o
);

    always_comb begin
        blk_o   = '0;
        extra_o = (r_i >= 6'(LEN_OFFSET));
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i < int'(r_i)) begin
                blk_o[8*i +: 8] = buf_i[8*i +: 8];
            end else if (i == int'(r_i)) begin
                blk_o[8*i +: 8] = PAD_BYTE;
            end
        end
        if (!extra_o) begin
            for (int i = 0; i < 8; i++) begin
                blk_o[8*(LEN_OFFSET+i) +: 8] = len_i[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/md5_padder.sv
`default_nettype none
// ============================================================================
//  Module      : md5_padder
//  Description : Byte-stream front end for md5_core. Collects bytes into
//                64-byte blocks, applies MD5 padding and issues each block
//                with blk_start (first of a message) or blk_resume. The fill
//                buffer and the issued block register form a double buffer,
//                so the next block fills while the core hashes.
//  Ports       : clk, rst_n           - clock, synchronous active-low reset
//                in_valid/in_ready    - byte transfer handshake
//                in_data              - message byte
//                in_last, in_empty    - end of message / byte-less transfer
//                blk_out              - block to core, byte i at [8i:8i+7]
//                blk_start/blk_resume - one-cycle issue pulses
//                core_done            - core idle / digest valid
//                msg_done             - final digest valid pulse
//                busy                 - message in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module md5_padder
    import md5_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [0:511] blk_out,
    output logic         blk_start,
    output logic         blk_resume,
    input  logic         core_done,
    output logic         msg_done,
    output logic         busy
);

    state_e           state_q, state_d;
    blk_t             buf_q;
    logic [6:0]       ptr_q, ptr_d;
    logic             full_q, full_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             started_q, started_d;
    logic             inflight_q, inflight_d;
    logic             seen_low_q, seen_low_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
    logic             blk_start_q, blk_start_d;
    logic             blk_resume_q, blk_resume_d;
    logic             msg_done_q, msg_done_d;
    blk_t             blk_q, blk_d;

    logic             w_accept;
    logic             w_byte;
    logic [63:0]      w_len64;
    blk_t             w_tail;
    logic             w_extra;
    blk_t             w_len_blk;
    blk_t             w_src;
    logic             w_have_blk;
    logic             w_issue;

    assign w_accept = in_valid && in_ready_q;
    // An empty terminator closes the message without contributing a byte.
    assign w_byte   = w_accept && !(in_last && in_empty);
    assign w_len64  = 64'(len_q);

    md5_pad_tail u_tail (
        .buf_i   (buf_q),
        .r_i     (ptr_q[5:0]),
        .len_i   (w_len64),
        .blk_o   (w_tail),
        .extra_o (w_extra)
    );

    always_comb begin
        w_len_blk = '0;
        for (int i = 0; i < 8; i++) begin
            w_len_blk[8*(LEN_OFFSET+i) +: 8] = w_len64[8*i +: 8];
        end
    end

    // Fill buffer storage: contents beyond ptr are never observed, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (w_byte) begin
            buf_q[{ptr_q[5:0], 3'b000} +: 8] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            ptr_q        <= '0;
            full_q       <= 1'b0;
            len_q        <= '0;
            started_q    <= 1'b0;
            inflight_q   <= 1'b0;
            seen_low_q   <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            blk_start_q  <= 1'b0;
            blk_resume_q <= 1'b0;
            msg_done_q   <= 1'b0;
            blk_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            full_q       <= full_d;
            len_q        <= len_d;
            started_q    <= started_d;
            inflight_q   <= inflight_d;
            seen_low_q   <= seen_low_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            blk_start_q  <= blk_start_d;
            blk_resume_q <= blk_resume_d;
            msg_done_q   <= msg_done_d;
            blk_q        <= blk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        full_d       = full_q;
        len_d        = len_q;
        started_d    = started_q;
        inflight_d   = inflight_q;
        seen_low_d   = seen_low_q;
        busy_d       = busy_q;
        blk_d        = blk_q;
        blk_start_d  = 1'b0;
        blk_resume_d = 1'b0;
        msg_done_d   = 1'b0;
        w_have_blk   = 1'b0;
        w_src        = buf_q;

        // A pending full data block always goes out before the padded tail.
        case (state_q)
            ST_FILL: begin
                w_have_blk = full_q;
            end
            ST_PAD: begin
                w_have_blk = 1'b1;
                w_src      = full_q ? buf_q : w_tail;
            end
            ST_EXTRA: begin
                w_have_blk = 1'b1;
                w_src      = w_len_blk;
            end
            default: begin
                w_have_blk = 1'b0;
            end
        endcase

        w_issue = w_have_blk && core_done && !inflight_q;

        // The core may still report done for a cycle or two after an issue;
        // only a low-then-high sequence marks the block as finished.
        if (inflight_q) begin
            if (!core_done) begin
                seen_low_d = 1'b1;
            end else if (seen_low_q) begin
                inflight_d = 1'b0;
                seen_low_d = 1'b0;
            end
        end

        if (w_accept) begin
            busy_d = 1'b1;
            if (w_byte) begin
                ptr_d = ptr_q + 7'd1;
                len_d = len_q + LEN_W'(8);
                if (ptr_q == 7'd63) begin
                    full_d = 1'b1;
                end
            end
            if (in_last) begin
                state_d = ST_PAD;
            end
        end

        if (w_issue) begin
            blk_d        = w_src;
            blk_start_d  = !started_q;
            blk_resume_d = started_q;
            started_d    = 1'b1;
            inflight_d   = 1'b1;
            seen_low_d   = 1'b0;
            full_d       = 1'b0;
            ptr_d        = '0;
            if (state_q == ST_PAD && !full_q) begin
                state_d = w_extra ? ST_EXTRA : ST_DRAIN;
            end else if (state_q == ST_EXTRA) begin
                state_d = ST_DRAIN;
            end
        end

        if (state_q == ST_DRAIN && !inflight_d) begin
            msg_done_d = 1'b1;
            busy_d     = 1'b0;
            started_d  = 1'b0;
            len_d      = '0;
            state_d    = ST_FILL;
        end

        in_ready_d = (state_d == ST_FILL) && !full_d;
    end

    assign in_ready   = in_ready_q;
    assign blk_out    = blk_q;
    assign blk_start  = blk_start_q;
    assign blk_resume = blk_resume_q;
    assign msg_done   = msg_done_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire
